// File: rtl/rv_core_pkg.sv
// -----------------------------------------------------------------------------
// rv_core_pkg
// Shared core constants and types: data width, register file geometry, the
// writeback request record and the major opcode encodings used by decode.
// -----------------------------------------------------------------------------
package rv_core_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] I_load = 7'b0000011;
    localparam logic [6:0] I_type = 7'b0010011;
    localparam logic [6:0] U_ADD  = 7'b0010111;  // auipc
    localparam logic [6:0] S      = 7'b0100011;
    localparam logic [6:0] R      = 7'b0110011;
    localparam logic [6:0] U_LOAD = 7'b0110111;  // lui
    localparam logic [6:0] B      = 7'b1100011;
    localparam logic [6:0] J      = 7'b1101111;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Priority starts at pointer_i+1 (mod N)
// and walks upward; the first asserted request wins.
//   req_i         : request vector
//   pointer_i     : index of the last winner
//   grant_o       : one-hot grant (all zero when no request)
//   grant_idx_o   : binary index of the winner (pointer_i when no request)
//   grant_valid_o : any grant this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] pointer_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    // Walk offsets from farthest to nearest so the nearest valid requester
    // after the pointer is the last (and therefore winning) assignment.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = pointer_i;
        grant_valid_o = 1'b0;
        for (int off = N; off >= 1; off--) begin
            if (req_i[(int'(pointer_i) + off) % N]) begin
                grant_o                                = '0;
                grant_o[(int'(pointer_i) + off) % N]   = 1'b1;
                grant_idx_o   = IDX_W'((int'(pointer_i) + off) % N);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-bank write port between N_REQ writeback sources.
// Round-robin arbitration picks one requester per cycle; the winning write is
// registered and appears on rf_* one cycle later. A per-register pending
// counter tracks issued-but-unwritten destinations and drives the RAW stall.
//
// Ports
//   clk, reset              : clock, asynchronous active-high reset
//   req_valid/ready         : per-requester write handshake
//   req_rd / req_data       : packed per-requester destination and data
//   issue_valid/rd/ready    : decode-side destination reservation
//   rs1/rs2_addr, _used     : decoded sources checked for hazards
//   stall                   : a used source has an outstanding producer
//   rf_we/waddr/wdata       : register bank write port
//   err_underflow           : sticky, a write hit a register with no pending
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import rv_core_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32,
    parameter int CNT_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*REG_AW-1:0] req_rd,
    input  logic [N_REQ*XLEN-1:0]   req_data,

    input  logic                    issue_valid,
    input  logic [REG_AW-1:0]       issue_rd,
    output logic                    issue_ready,

    input  logic [REG_AW-1:0]       rs1_addr,
    input  logic [REG_AW-1:0]       rs2_addr,
    input  logic                    rs1_used,
    input  logic                    rs2_used,
    output logic                    stall,

    output logic                    rf_we,
    output logic [REG_AW-1:0]       rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic                    err_underflow
);

    localparam int               IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i         (req_valid),
        .pointer_i     (ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign req_ready = reset ? '0 : grant;
    assign ptr_d     = grant_valid ? grant_idx : ptr_q;

    logic [REG_AW-1:0] win_rd;
    logic [XLEN-1:0]   win_data;
    logic              wr_fire;

    always_comb begin
        win_rd   = req_rd[int'(grant_idx)*REG_AW +: REG_AW];
        win_data = req_data[int'(grant_idx)*XLEN +: XLEN];
    end

    // x0 writes are accepted but never reach the bank.
    assign wr_fire = grant_valid && (win_rd != '0);

    // -------------------------------------------------------------------------
    // Registered write port
    // -------------------------------------------------------------------------
    logic              rf_we_q;
    logic [REG_AW-1:0] rf_waddr_q;
    logic [XLEN-1:0]   rf_wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= IDX_W'(N_REQ - 1);
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            rf_we_q <= wr_fire;
            if (wr_fire) begin
                rf_waddr_q <= win_rd;
                rf_wdata_q <= win_data;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // -------------------------------------------------------------------------
    // Pending-write scoreboard
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             err_q, err_d;
    logic             issue_fire;
    logic             wb_hit;
    logic             wb_zero;
    logic             same_reg;

    assign issue_ready = !reset && ((issue_rd == '0) || (cnt_q[issue_rd] != CNT_MAX));
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
    assign wb_zero     = rf_we_q && (cnt_q[rf_waddr_q] == '0);
    assign wb_hit      = rf_we_q && !wb_zero;
    // A real decrement and an increment on the same register cancel out.
    assign same_reg    = issue_fire && wb_hit && (rf_waddr_q == issue_rd);
    assign err_d       = err_q || wb_zero;

    always_comb begin
        cnt_d = cnt_q;
        if (issue_fire && !same_reg) begin
            cnt_d[issue_rd] = cnt_q[issue_rd] + CNT_W'(1);
        end
        if (wb_hit && !same_reg) begin
            cnt_d[rf_waddr_q] = cnt_q[rf_waddr_q] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_underflow = err_q;

    // Counter only drops after the rf_we cycle, so stall covers that cycle too.
    assign stall = (rs1_used && (rs1_addr != '0) && (cnt_q[rs1_addr] != '0)) ||
                   (rs2_used && (rs2_addr != '0) && (cnt_q[rs2_addr] != '0));

endmodule
